inv_cast: RTL and testbench
===========================

INV_CAST -- requirements
Module: inv_cast

Interface
REQ-001 Parameter BLOCK_LEN, default 4, is the number of values per block and SHALL be a power of two from 1 to 64.
REQ-002 clk  input  1  is the single clock; all state changes on its rising edge.
REQ-003 reset  input  1  is the reset; it SHALL be asynchronous and active-low.
REQ-004 s_ex_data  input  11  is the block exponent code E (0 means an all-zero block).
REQ-005 s_ex_valid  input  1  marks E as valid.
REQ-006 s_ex_ready  output  1  acknowledges E; it SHALL be asserted once per block.
REQ-007 s_int_data  input  64  is the block-floating-point integer c, two's complement.
REQ-008 s_int_valid  input  1  marks c as valid.
REQ-009 s_int_ready  output  1  acknowledges c.
REQ-010 m_fp_data  output  64  is the reconstructed IEEE-754 double.
REQ-011 m_fp_valid  output  1  marks m_fp_data as valid.
REQ-012 m_fp_ready  input  1  is downstream acceptance.

Function
REQ-013 Internal sync SHALL be s_ex_valid && s_int_valid && (!m_fp_valid || m_fp_ready).
REQ-014 s_int_ready SHALL equal sync, and s_ex_ready SHALL equal sync && (count == BLOCK_LEN-1), both combinationally.
REQ-015 count SHALL be a log2(BLOCK_LEN)-bit index: +1 on sync, wrap from BLOCK_LEN-1 to 0, hold otherwise; with BLOCK_LEN=1, s_ex_ready SHALL equal sync.
REQ-016 E SHALL be held, not consumed, across all BLOCK_LEN values of a block; the upstream is required to keep s_ex_data stable until s_ex_ready.
REQ-017 Latency SHALL be 1 cycle: on sync, m_fp_data and m_fp_valid=1 register on the same edge.
REQ-018 If m_fp_ready=1 with no sync, m_fp_valid SHALL clear to 0. If m_fp_valid=1 and m_fp_ready=0, m_fp_data and m_fp_valid SHALL hold.
REQ-019 Full throughput SHALL be one value per cycle when all valids and m_fp_ready stay high.
REQ-020 Conversion SHALL compute value = c * 2^(E-1085).
- sign = c[63]
- mag = |c| as a 64-bit unsigned; c = -2^63 gives mag = 2^63
REQ-021 If mag == 0, the output SHALL be 0x0000000000000000.
REQ-022 Otherwise, with p = bit index of the leading one of mag (0..63):
- biased exponent X = p + E - 62, computed signed with at least 13 bits
- fraction = the 52 bits directly below the leading one, left-aligned, zero-filled when p < 52
REQ-023 Bits below the 52-bit fraction SHALL be truncated (round toward zero); no rounding increment is applied.
REQ-024 If X <= 0, the output SHALL be signed zero {sign, 63'b0}; subnormals are not produced.
REQ-025 If X >= 2047, the output SHALL be signed infinity {sign, 11'h7FF, 52'b0}.
REQ-026 Otherwise the output SHALL be {sign, X[10:0], fraction}.
REQ-027 Leading-one detection and packing SHALL complete combinationally within the 1-cycle latency.

Reset
REQ-028 While reset=0, the block SHALL hold: count=0, m_fp_valid=0, m_fp_data=0; s_ex_ready and s_int_ready then follow REQ-014 (0 while m_fp_valid=0 and the inputs are invalid).
REQ-029 Reset asserted mid-block SHALL discard the partial block and any pending output; after release, the next E is taken as a new block with count=0.

Verification
REQ-030 E=1024, c=0x4000000000000000 -> m_fp_data=0x4000000000000000 (2.0) one cycle after sync.
REQ-031 E=1024, c=0xE000000000000000 (-2^61) -> 0xBFF0000000000000 (-1.0). E=1024, c=0x8000000000000000 -> 0xC010000000000000 (-4.0).
REQ-032 c=0 with any E -> 0x0. E=1, c=1 -> 0x0 (flush). E=2047, c=0x7FFFFFFFFFFFFFFF -> 0x7FF0000000000000 (+inf).
REQ-033 Block of 4 values, E=1024, c = 2^62, 2^61, 2^60, 0 -> outputs 2.0, 1.0, 0.5, 0.0; s_ex_ready high only on the 4th sync.
- Hold m_fp_ready=0 for 3 cycles after the 1st output -> m_fp_data holds 0x4000000000000000, s_int_ready=0; the stream resumes with no loss or duplication.
REQ-034 Reset pulse after 2 of 4 values accepted -> m_fp_valid=0 immediately.
- A new full block then outputs correctly, and s_ex_ready asserts on its 4th value, not its 2nd.

Source files
------------

// File: rtl/inv_cast_if.sv
// Stream bundle for inv_cast: block exponent, block integer and reconstructed double.
// The slave modport is the converter side, the master modport is the environment side.
interface inv_cast_if;
  logic [10:0] s_ex_data;
  logic        s_ex_valid;
  logic        s_ex_ready;
  logic [63:0] s_int_data;
  logic        s_int_valid;
  logic        s_int_ready;
  logic [63:0] m_fp_data;
  logic        m_fp_valid;
  logic        m_fp_ready;

  modport slave (
    input  s_ex_data, s_ex_valid, s_int_data, s_int_valid, m_fp_ready,
    output s_ex_ready, s_int_ready, m_fp_data, m_fp_valid
  );

  modport master (
    output s_ex_data, s_ex_valid, s_int_data, s_int_valid, m_fp_ready,
    input  s_ex_ready, s_int_ready, m_fp_data, m_fp_valid
  );
endinterface

// File: rtl/inv_cast.sv
// Block-floating-point to IEEE-754 double converter: value = c * 2^(E-1085),
// one value per cycle, truncating, flush-to-zero and saturate-to-infinity.
module inv_cast #(
  parameter int unsigned BLOCK_LEN = 4
) (
  input  logic         clk,
  input  logic         reset,
  inv_cast_if.slave    bus
);
  localparam int unsigned CW       = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
  localparam int unsigned FRAC_W   = 52;
  localparam int unsigned EXP_W    = 11;
  localparam int unsigned XW       = 14;

  logic [CW-1:0]        count;
  logic                 sync;
  logic                 last;

  logic                 sign;
  logic [63:0]          mag;
  logic [5:0]           lead;
  logic signed [XW-1:0] x;
  logic [FRAC_W-1:0]    fraction;
  logic [63:0]          packed_fp;

  // Handshake: the exponent is only acknowledged on the last value of a block.
  assign sync = bus.s_ex_valid && bus.s_int_valid && (!bus.m_fp_valid || bus.m_fp_ready);
  assign last = (BLOCK_LEN == 1) || (count == CW'(BLOCK_LEN - 1));
  assign bus.s_int_ready = sync;
  assign bus.s_ex_ready  = sync && last;

  // Magnitude, leading-one position and IEEE packing.
  always_comb begin
    sign      = bus.s_int_data[63];
    mag       = sign ? (~bus.s_int_data + 64'd1) : bus.s_int_data;
    lead      = 6'd0;
    for (int i = 0; i < 64; i++) begin
      if (mag[i]) lead = 6'(i);
    end
    x         = $signed({8'd0, lead}) + $signed({3'd0, bus.s_ex_data}) - 14'sd62;
    // Normalise so the leading one sits at bit 63; the 52 bits below it are the fraction.
    fraction  = FRAC_W'((mag << (6'd63 - lead)) >> 11);
    packed_fp = 64'd0;
    if (mag == 64'd0) begin
      packed_fp = 64'd0;
    end else if (x <= 14'sd0) begin
      packed_fp = {sign, 63'd0};
    end else if (x >= 14'sd2047) begin
      packed_fp = {sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    end else begin
      packed_fp = {sign, x[EXP_W-1:0], fraction};
    end
  end

  // Block index and single-stage output register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count          <= '0;
      bus.m_fp_valid <= 1'b0;
      bus.m_fp_data  <= 64'd0;
    end else begin
      if (sync) begin
        count          <= last ? '0 : count + CW'(1);
        bus.m_fp_data  <= packed_fp;
        bus.m_fp_valid <= 1'b1;
      end else if (bus.m_fp_ready) begin
        bus.m_fp_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_inv_cast.sv
// Directed bench for inv_cast (BLOCK_LEN=4) with hand-computed doubles.
module tb_inv_cast;
  logic clk;
  logic reset;
  int   checks;
  int   failures;

  inv_cast_if bus();

  inv_cast #(.BLOCK_LEN(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  // One accepted value: checks both readies before the edge and the output after it.
  task automatic xfer(input string tag, input logic [10:0] e, input logic [63:0] c,
                      input logic [63:0] exp, input logic exp_exr);
    bus.s_ex_data   = e;
    bus.s_int_data  = c;
    bus.s_ex_valid  = 1'b1;
    bus.s_int_valid = 1'b1;
    #1;
    check({tag, "_int_rdy"}, 64'(bus.s_int_ready), 64'd1);
    check({tag, "_ex_rdy"},  64'(bus.s_ex_ready),  64'(exp_exr));
    @(posedge clk); #1;
    check({tag, "_valid"}, 64'(bus.m_fp_valid), 64'd1);
    check({tag, "_data"},  bus.m_fp_data, exp);
  endtask

  task automatic idle();
    bus.s_ex_valid  = 1'b0;
    bus.s_int_valid = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    bus.s_ex_data   = 11'd0;
    bus.s_int_data  = 64'd0;
    bus.s_ex_valid  = 1'b0;
    bus.s_int_valid = 1'b0;
    bus.m_fp_ready  = 1'b1;
    #12;
    check("rst_valid",   64'(bus.m_fp_valid),  64'd0);
    check("rst_data",    bus.m_fp_data,        64'd0);
    check("rst_ex_rdy",  64'(bus.s_ex_ready),  64'd0);
    check("rst_int_rdy", 64'(bus.s_int_ready), 64'd0);
    reset = 1'b1;

    // Sign handling and the -2^63 corner, back to back.
    xfer("a0", 11'd1024, 64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000, 1'b0);
    xfer("a1", 11'd1024, 64'hE000_0000_0000_0000, 64'hBFF0_0000_0000_0000, 1'b0);
    xfer("a2", 11'd1024, 64'h8000_0000_0000_0000, 64'hC010_0000_0000_0000, 1'b0);
    xfer("a3", 11'd1024, 64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000, 1'b1);

    // Flush to signed zero and smallest normal with a full fraction.
    xfer("b0", 11'd1, 64'h0000_0000_0000_0001, 64'h0000_0000_0000_0000, 1'b0);
    xfer("b1", 11'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h001F_FFFF_FFFF_FFFF, 1'b0);
    xfer("b2", 11'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b0);
    xfer("b3", 11'd1, 64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000, 1'b1);

    // Saturation to infinity and the largest finite exponent.
    xfer("c0", 11'd2047, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FF0_0000_0000_0000, 1'b0);
    xfer("c1", 11'd2047, 64'hC000_0000_0000_0000, 64'hFFF0_0000_0000_0000, 1'b0);
    xfer("c2", 11'd2047, 64'h2000_0000_0000_0000, 64'h7FE0_0000_0000_0000, 1'b0);
    xfer("c3", 11'd2047, 64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000, 1'b1);

    // Unit scale: small integers, fraction left-aligned, low bit truncated.
    xfer("d0", 11'd1085, 64'h0000_0000_0000_0003, 64'h4008_0000_0000_0000, 1'b0);
    xfer("d1", 11'd1085, 64'h0020_0000_0000_0001, 64'h4340_0000_0000_0000, 1'b0);
    xfer("d2", 11'd1085, 64'hFFFF_FFFF_FFFF_FFFE, 64'hC000_0000_0000_0000, 1'b0);
    xfer("d3", 11'd1085, 64'h0000_0000_0000_0001, 64'h3FF0_0000_0000_0000, 1'b1);

    // Backpressure in the middle of a block.
    xfer("e0", 11'd1024, 64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000, 1'b0);
    bus.m_fp_ready = 1'b0;
    bus.s_int_data = 64'h2000_0000_0000_0000;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_int_rdy", 64'(bus.s_int_ready), 64'd0);
      check("bp_ex_rdy",  64'(bus.s_ex_ready),  64'd0);
      @(posedge clk); #1;
      check("bp_valid", 64'(bus.m_fp_valid), 64'd1);
      check("bp_data",  bus.m_fp_data, 64'h4000_0000_0000_0000);
    end
    bus.m_fp_ready = 1'b1;
    xfer("e1", 11'd1024, 64'h2000_0000_0000_0000, 64'h3FF0_0000_0000_0000, 1'b0);
    xfer("e2", 11'd1024, 64'h1000_0000_0000_0000, 64'h3FE0_0000_0000_0000, 1'b0);
    xfer("e3", 11'd1024, 64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000, 1'b1);
    idle();
    @(posedge clk); #1;
    check("drain_valid", 64'(bus.m_fp_valid), 64'd0);

    // Reset after two values of a block discards the partial block.
    xfer("f0", 11'd1024, 64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000, 1'b0);
    xfer("f1", 11'd1024, 64'h2000_0000_0000_0000, 64'h3FF0_0000_0000_0000, 1'b0);
    idle();
    reset = 1'b0;
    #1;
    check("mid_rst_valid", 64'(bus.m_fp_valid), 64'd0);
    check("mid_rst_data",  bus.m_fp_data,       64'd0);
    #2;
    reset = 1'b1;
    xfer("g0", 11'd1024, 64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000, 1'b0);
    xfer("g1", 11'd1024, 64'h2000_0000_0000_0000, 64'h3FF0_0000_0000_0000, 1'b0);
    xfer("g2", 11'd1024, 64'h1000_0000_0000_0000, 64'h3FE0_0000_0000_0000, 1'b0);
    xfer("g3", 11'd1024, 64'hC000_0000_0000_0000, 64'hC000_0000_0000_0000, 1'b1);
    idle();
    @(posedge clk); #1;
    check("end_valid", 64'(bus.m_fp_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
